stream_packetizer: RTL
======================

# stream_packetizer

- Sits directly downstream of `queue` / `stream_fifo` and consumes their 32-bit output stream.
- Groups accepted words into packets of 1..MAX_BURST payload words, then appends one trailer word carrying a sequence number and the payload count; the trailer is marked with `s_tlast`.
- Closes a packet early when the upstream has been idle for TIMEOUT cycles.
- The output is a single registered stage feeding the NoC injection side.

## Interface
Parameters:
- DATA_WIDTH, 32, stream word width; fixed at 32 (trailer format depends on it).
- MAX_BURST, 16, maximum payload words per packet; legal range 1..255.
- TIMEOUT, 64, upstream-idle cycles before an early close; 0 disables the timeout.

Ports:
- clk  in  1  clock; one clock domain; everything is sampled on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- m_tdata  in  32  upstream data (from the queue output).
- m_tvalid  in  1  upstream valid.
- m_tready  out  1  ready to upstream.
- s_tdata  out  32  downstream data.
- s_tvalid  out  1  downstream valid.
- s_tlast  out  1  high on the trailer word only.
- s_tready  in  1  downstream ready.

## Operation
- Transfer rule: a transfer happens on a side when valid && ready on a clock edge.
- State machine: IDLE (cnt=0), PAYLOAD (1 ≤ cnt < MAX_BURST), TRAILER (trailer pending).
- Output register:
  - Loads when `!s_tvalid || s_tready`.
  - `m_tready = (state != TRAILER) && (!s_tvalid || s_tready) && !rst`.
- Accepting a word:
  - The word goes into the output register with `s_tlast=0`.
  - cnt increments and idle_cnt clears.
- Transitions:
  - IDLE → PAYLOAD on an accepted word.
  - PAYLOAD → TRAILER when the accepted word makes cnt == MAX_BURST.
  - PAYLOAD → TRAILER when idle_cnt reaches TIMEOUT.
- idle_cnt:
  - Increments only in PAYLOAD on cycles with `m_tvalid=0`.
  - Cycles stalled by downstream backpressure (m_tvalid=1, m_tready=0) do not count.
- TRAILER:
  - When the output register is free, load `{8'hA5, seq[7:0], 8'h00, cnt[7:0]}` with `s_tlast=1`.
  - In the same edge: seq increments (mod 256), cnt and idle_cnt clear, state → IDLE.
- Payload data passes through unmodified.
- Trailer cnt is always 1..MAX_BURST; an empty packet is never emitted.
- MAX_BURST=1: every payload word is followed by a trailer.
- A timeout fires only in PAYLOAD; IDLE never times out.
- Simultaneous idle_cnt reaching TIMEOUT and an arriving `m_tvalid` cannot occur, because a counted cycle implies `m_tvalid=0`.
- Reset mid-packet discards the partial packet: no trailer is emitted and seq restarts at 0.

## Timing
- Reset values:
  - Outputs: `s_tvalid=0`, `s_tlast=0`, `s_tdata=0`, `m_tready=0` while rst=1.
  - Internal: state=IDLE, cnt=0, idle_cnt=0, seq=0.
- `m_tready=1` in the first cycle after rst deasserts.
- Payload latency: a word accepted at edge N appears on `s_tdata` after edge N (visible in cycle N+1).
- Throughput is one word per cycle while `s_tready=1`.
- The trailer costs exactly one upstream bubble: `m_tready=0` for one cycle per packet when `s_tready=1`.
- Timeout trailer: the TIMEOUT-th consecutive idle cycle triggers TRAILER, and the trailer is loaded on the following edge if the register is free.
- AXI-Stream rules:
  - Once `s_tvalid=1`, `s_tdata`/`s_tlast` hold stable until `s_tready`.
  - `s_tvalid` never drops without a transfer.
- `m_tready` depends combinationally on `s_tready`; there is no comb path from `m_tvalid` to `m_tready`.

## Test plan
All scenarios use MAX_BURST=4 and TIMEOUT=8.
- Full packet: stream 0x11,0x22,0x33,0x44 back-to-back with `s_tready=1` → out 0x11,0x22,0x33,0x44 then 0xA5000004 with tlast=1; `m_tready` low exactly one cycle.
- Sequence wrap: 257 full packets → trailers carry seq 0x00..0xFF, then 0x00 (e.g. 0xA5FF0004, then 0xA5000004).
- Timeout: send 0xAA,0xBB, then `m_tvalid=0` → after 8 idle cycles, trailer 0xA5000002 with tlast=1; no trailer if idle starts in IDLE.
- Backpressure: `s_tready` toggles randomly (50%) over 40 words → output equals input plus a trailer after every 4 words; data/tlast stable while stalled; no loss or duplication.
- Reset mid-packet: rst=1 for one cycle after 2 words → `s_tvalid=0` next cycle; the next 4 words produce trailer 0xA5000004 (seq restarted at 0).
- Stall does not time out: after 1 word, hold `s_tready=0` with `m_tvalid=1` for 20 cycles → no early trailer; the packet completes at 4 words.

Source files
------------

// File: rtl/stream_packetizer.sv
// Packs an upstream word stream into packets of 1..MAX_BURST payload words,
// each followed by a trailer {A5, seq, 00, count} marked with s_tlast.
module stream_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tvalid,
  output logic                  m_tready,
  output logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tvalid,
  output logic                  s_tlast,
  input  logic                  s_tready
);

  localparam int IW = $clog2(TIMEOUT + 2);
  localparam logic [7:0]    MB_W = 8'(MAX_BURST);
  localparam logic [IW-1:0] TO_W = IW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              seq_q, seq_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;

  logic                    load_ok;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   trailer;

  // The output register can take a new word when empty or draining this edge.
  assign load_ok  = !tvalid_q || s_tready;
  assign m_tready = (state_q != TRAILER) && load_ok && !rst;
  assign accept   = m_tvalid && m_tready;
  assign trailer  = {8'hA5, seq_q, 8'h00, cnt_q};

  assign s_tdata  = tdata_q;
  assign s_tvalid = tvalid_q;
  assign s_tlast  = tlast_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    idle_d   = idle_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (load_ok) begin
      tvalid_d = 1'b0;
    end
    if (accept) begin
      tdata_d  = m_tdata;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 8'd1;
          idle_d  = '0;
          state_d = (MAX_BURST == 1) ? TRAILER : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          cnt_d  = cnt_q + 8'd1;
          idle_d = '0;
          if (cnt_q + 8'd1 == MB_W) begin
            state_d = TRAILER;
          end
        end else if (!m_tvalid && (TIMEOUT != 0)) begin
          // Only genuinely idle cycles count; backpressure stalls hold m_tvalid high.
          idle_d = idle_q + IW'(1);
          if (idle_q + IW'(1) == TO_W) begin
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (load_ok) begin
          tdata_d  = trailer;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          seq_d    = seq_q + 8'd1;
          cnt_d    = 8'd0;
          idle_d   = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      seq_q    <= 8'd0;
      idle_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      idle_q   <= idle_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

endmodule
